// File: rtl/trap_pkg.sv
// Shared types and constants for the MIPS32 trap unit.
// Condition codes and FSM state encoding.
package trap_pkg;

    localparam logic [2:0] TR_EQ  = 3'b000;
    localparam logic [2:0] TR_NE  = 3'b001;
    localparam logic [2:0] TR_GE  = 3'b010;
    localparam logic [2:0] TR_GEU = 3'b011;
    localparam logic [2:0] TR_LT  = 3'b100;
    localparam logic [2:0] TR_LTU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } trap_state_e;

endpackage

// File: rtl/trap_compare.sv
// Combinational evaluation of the six MIPS trap conditions.
// Codes 110 and 111 never evaluate true.
module trap_compare
    import trap_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cond_true
);

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             eq;
    logic             lt_u;
    logic             lt_s;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign a_s  = {~a[WIDTH-1], a[WIDTH-2:0]};
    assign b_s  = {~b[WIDTH-1], b[WIDTH-2:0]};
    assign eq   = (a == b);
    assign lt_u = (a < b);
    assign lt_s = (a_s < b_s);

    always_comb begin
        cond_true = 1'b0;
        unique case (1'b1)
            (cond == TR_EQ):  cond_true = eq;
            (cond == TR_NE):  cond_true = ~eq;
            (cond == TR_GE):  cond_true = ~lt_s;
            (cond == TR_GEU): cond_true = ~lt_u;
            (cond == TR_LT):  cond_true = lt_s;
            (cond == TR_LTU): cond_true = lt_u;
            default:          cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/trap_unit.sv
// Trap exception unit: detects EX-stage traps and holds a
// req/ack request to CP0 with faulting PC, condition and count.
module trap_unit
    import trap_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ex_valid,
    input  logic                 ex_trap,
    input  logic [2:0]           ex_cond,
    input  logic [WIDTH-1:0]     ex_a,
    input  logic [WIDTH-1:0]     ex_b,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic                 ex_stall,
    input  logic                 ex_flush,
    input  logic                 m_flush,
    input  logic                 trap_ack,
    output logic                 exc_tr_ex,
    output logic                 trap_req,
    output logic                 trap_busy,
    output logic [PC_WIDTH-1:0]  trap_pc,
    output logic [2:0]           trap_cond,
    output logic [CNT_WIDTH-1:0] trap_count
);

    trap_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [2:0]           cond_q, cond_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 cond_true;

    trap_compare #(.WIDTH(WIDTH)) u_cmp (
        .cond      (ex_cond),
        .a         (ex_a),
        .b         (ex_b),
        .cond_true (cond_true)
    );

    assign exc_tr_ex = ex_valid & ex_trap & cond_true;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cond_d  = cond_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_tr_ex & ~ex_stall & ~ex_flush & ~m_flush) begin
                    state_d = ST_PEND;
                    pc_d    = ex_pc;
                    cond_d  = ex_cond;
                end
            end
            ST_PEND: begin
                // An older exception supersedes the trap, even if acked.
                if (m_flush) begin
                    state_d = ST_IDLE;
                end else if (trap_ack) begin
                    state_d = ST_IDLE;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cond_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
        end
    end

    assign trap_req   = (state_q == ST_PEND);
    assign trap_busy  = (state_q == ST_PEND);
    assign trap_pc    = pc_q;
    assign trap_cond  = cond_q;
    assign trap_count = cnt_q;

endmodule

// File: doc/trap_unit.md
# trap_unit

Parametrised trap-exception unit for the MIPS32 pipeline, between EX and the CP0 exception controller. Evaluates all six MIPS trap conditions (TEQ/TNE/TGE/TGEU/TLT/TLTU and immediate forms) on full operands rather than a precomputed ALU result. Registers a detected trap into a pending request with a req/ack handshake to CP0. Holds the faulting PC, condition code and a saturating trap counter.

## Interface
- `WIDTH`, 32: operand width in bits (≥2)
- `PC_WIDTH`, 32: width of captured PC
- `CNT_WIDTH`, 16: trap counter width

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset (one clock; async assert, polarity fixed)
- `ex_valid`  in  1  EX-stage instruction valid
- `ex_trap`  in  1  EX instruction is a trap-class instruction
- `ex_cond`  in  3  trap condition code (encoding in Structure)
- `ex_a`  in  WIDTH  rs operand
- `ex_b`  in  WIDTH  rt operand or sign-extended immediate
- `ex_pc`  in  PC_WIDTH  PC of EX instruction
- `ex_stall`  in  1  EX held this cycle; no capture
- `ex_flush`  in  1  EX instruction cancelled; no capture
- `m_flush`  in  1  older exception wins; cancels pending trap
- `trap_ack`  in  1  CP0 accepted trap request
- `exc_tr_ex`  out  1  combinational EX-stage trap detect (hazard/forwarding use)
- `trap_req`  out  1  registered trap request to CP0
- `trap_busy`  out  1  pipeline hold while request pending
- `trap_pc`  out  PC_WIDTH  PC of trapping instruction
- `trap_cond`  out  3  condition code of trapping instruction
- `trap_count`  out  CNT_WIDTH  accepted traps, saturating

## Operation
- Condition true: EQ a==b; NE a!=b; GE signed a≥b; GEU unsigned a≥b; LT signed a<b; LTU unsigned a<b; codes 110/111 never true.
- `exc_tr_ex = ex_valid & ex_trap & cond_true`; no gating by stall or flush.
- FSM states IDLE, PEND:
  - IDLE→PEND when `exc_tr_ex & !ex_stall & !ex_flush & !m_flush`. Captures `trap_pc<=ex_pc`, `trap_cond<=ex_cond`.
  - PEND→IDLE on `trap_ack`. Increments `trap_count` unless it is all-ones (saturate).
  - PEND→IDLE on `m_flush`. No count.
  - `trap_ack` and `m_flush` in the same cycle: go IDLE and do not count (flush wins).
  - PEND with neither: hold all outputs.
- `trap_req = trap_busy = (state==PEND)`.
- EX trap detections while in PEND are ignored; the pipeline is held by `trap_busy`.
- `trap_ack` in IDLE is ignored.
- Reset: state IDLE, `trap_req`/`trap_busy` 0, `trap_pc` 0, `trap_cond` 0, `trap_count` 0.
- Reset asserted mid-PEND drops the request immediately (async) with no count.

## Timing
- `exc_tr_ex`: zero latency, combinational from EX inputs.
- `trap_req`: high the cycle after the capturing edge. Minimum request width is one cycle; ack is sampled on the same edge.
- Back-to-back traps: after ack returns to IDLE, a new capture is possible on the next edge. Best case is one idle cycle between requests.
- `trap_count` updates on the ack edge, visible the next cycle.
- `trap_pc` and `trap_cond` are stable for the whole of PEND. After PEND they retain their last value until the next capture.

## Structure
- Package `trap_pkg`:
  - condition localparams `TR_EQ=3'b000`, `TR_NE=3'b001`, `TR_GE=3'b010`, `TR_GEU=3'b011`, `TR_LT=3'b100`, `TR_LTU=3'b101`
  - state encoding `ST_IDLE=1'b0`, `ST_PEND=1'b1`
- Sub-module `trap_compare`, parametrised by WIDTH, purely combinational: `(cond, a, b) -> cond_true`.
  - Signed compare via MSB-inverted unsigned compare.
  - Equality shared with EQ/NE.
- Top module holds the FSM, capture registers and counter.

## Test plan
- TGE, WIDTH=32: `a=32'hFFFF_FFFF`, `b=0`, valid, no stall → `exc_tr_ex=0`, no request.
  - Same with TGEU → `exc_tr_ex=1`; `trap_req=1` next cycle; `trap_pc=ex_pc=32'h0040_0010`; `trap_cond=3'b011`.
- TEQ `a=b=5` with `ex_stall=1` for 2 cycles, then released → no capture while stalled; capture on the first unstalled edge.
  - Same with `ex_flush=1` → never captured.
- PEND held 3 cycles, then `trap_ack` → `trap_req` drops next cycle; `trap_count` 0→1.
  - Second TLT trap (`a=-1`, `b=0`) captured one cycle later.
- PEND with `trap_ack=1` and `m_flush=1` in the same cycle → IDLE, `trap_count` unchanged.
- `CNT_WIDTH=2`: five acked traps → `trap_count` sequence 1,2,3,3,3.
- Reserved code 3'b110 with any operands → no detect. `reset_n` pulsed low mid-PEND → all outputs 0 immediately.
